// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs an interval timer, services its timeouts and
// snapshots the live counter on request.
module timer_ctrl_master #(
    parameter bit CONTINUOUS = 1'b1,
    parameter bit IRQ_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] period,
    input  logic        snap_req,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        irq,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST,
        SNAP_W, SNAP_RL, SNAP_RH, SNAP_CAP, WR_STOP, STOP_CLR
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_period;
    logic        r_stop_pend, r_snap_pend;
    logic [15:0] r_tick_count;
    logic [31:0] r_snap_value;
    logic        r_snap_valid;
    logic        w_stop_req, w_snap_req;

    // A request seen this cycle acts immediately, otherwise it waits in its pending flag.
    assign w_stop_req = r_stop_pend | stop;
    assign w_snap_req = r_snap_pend | snap_req;

    always_comb begin
        w_next         = r_state;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = '0;
        avm_writedata  = '0;
        tick           = 1'b0;
        busy           = (r_state != IDLE);
        case (r_state)
            IDLE: if (start) w_next = WR_PL;
            WR_PL: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd2; avm_writedata = r_period[15:0];
                w_next = WR_PH;
            end
            WR_PH: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd3; avm_writedata = r_period[31:16];
                w_next = WR_CTRL;
            end
            WR_CTRL: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd1;
                avm_writedata = {12'b0, 1'b0, 1'b1, CONTINUOUS, IRQ_ENABLE};
                w_next = RUN;
            end
            RUN: begin
                if (w_stop_req)      w_next = WR_STOP;
                else if (irq)        w_next = CLR_ST;
                else if (w_snap_req) w_next = SNAP_W;
            end
            CLR_ST: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd0;
                tick = 1'b1;
                w_next = RUN;
            end
            SNAP_W: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd4;
                w_next = SNAP_RL;
            end
            SNAP_RL: begin
                avm_chipselect = 1'b1;
                avm_address = 3'd4;
                w_next = SNAP_RH;
            end
            SNAP_RH: begin
                avm_chipselect = 1'b1;
                avm_address = 3'd5;
                w_next = SNAP_CAP;
            end
            SNAP_CAP: w_next = RUN;
            WR_STOP: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd1; avm_writedata = 16'h0008;
                w_next = STOP_CLR;
            end
            STOP_CLR: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd0;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_period     <= '0;
            r_stop_pend  <= 1'b0;
            r_snap_pend  <= 1'b0;
            r_tick_count <= '0;
            r_snap_value <= '0;
            r_snap_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start)
                r_period <= period;

            if (w_next == WR_STOP || w_next == IDLE)
                r_stop_pend <= 1'b0;
            else if (r_state != IDLE && stop)
                r_stop_pend <= 1'b1;

            // Stopping drops an outstanding snapshot request.
            if (w_next == SNAP_W || w_next == WR_STOP || w_next == IDLE)
                r_snap_pend <= 1'b0;
            else if (r_state != IDLE && snap_req)
                r_snap_pend <= 1'b1;

            if (r_state == CLR_ST)
                r_tick_count <= r_tick_count + 16'd1;

            // Read data lags the address by one cycle: low half lands in SNAP_RH, high in SNAP_CAP.
            if (r_state == SNAP_RH)
                r_snap_value[15:0] <= avm_readdata;
            if (r_state == SNAP_CAP)
                r_snap_value[31:16] <= avm_readdata;
            r_snap_valid <= (r_state == SNAP_CAP);
        end
    end

    assign tick_count = r_tick_count;
    assign snap_value = r_snap_value;
    assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Directed/randomized bench for timer_ctrl_master with a behavioural timer slave
// and an access log compared against the expected bus transactions.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n, start, stop, snap_req;
    logic [31:0] period;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata;
    logic [15:0] avm_readdata = 16'hDEAD;
    logic        irq;
    logic        busy, tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;

    always #5 clk = ~clk;

    timer_ctrl_master #(.CONTINUOUS(1'b1), .IRQ_ENABLE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .period(period), .snap_req(snap_req),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .irq(irq),
        .busy(busy), .tick(tick), .tick_count(tick_count),
        .snap_value(snap_value), .snap_valid(snap_valid)
    );

    // Timer slave: timeout flag set by the bench, cleared by any write to status.
    logic        to_flag = 1'b0;
    logic        irq_pulse, irq_hold;
    logic [31:0] tmr_count, snap_reg = '0;
    assign irq = to_flag;

    always @(posedge clk) begin
        if (irq_pulse || irq_hold)
            to_flag <= 1'b1;
        else if (avm_chipselect && !avm_write_n && avm_address == 3'd0)
            to_flag <= 1'b0;
        if (avm_chipselect && !avm_write_n && avm_address == 3'd4)
            snap_reg <= tmr_count;
        if (avm_chipselect && avm_write_n)
            avm_readdata <= (avm_address == 3'd4) ? snap_reg[15:0] :
                            (avm_address == 3'd5) ? snap_reg[31:16] : 16'h0000;
        else
            avm_readdata <= 16'hDEAD;
    end

    // Bus/pulse monitor.
    typedef struct packed {logic [2:0] a; logic wn; logic [15:0] d;} acc_t;
    acc_t        log_q[$];
    int unsigned tick_seen = 0, snap_seen = 0;
    logic [31:0] snap_seen_val = '0;

    always @(negedge clk) begin
        if (avm_chipselect) log_q.push_back('{avm_address, avm_write_n, avm_writedata});
        if (tick) tick_seen++;
        if (snap_valid) begin
            snap_seen++;
            snap_seen_val = snap_value;
        end
    end

    int unsigned n_checks = 0, n_pass = 0;
    logic [15:0] exp_ticks = '0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic chk_acc(input string name, input int unsigned idx,
                           input logic [2:0] a, input logic wn, input logic [15:0] d);
        logic [20:0] obs, exp;
        obs = (idx < log_q.size()) ? {1'b1, log_q[idx]} : 21'h0;
        exp = {1'b1, a, wn, d};
        check(name, 32'(obs), 32'(exp));
    endtask

    function automatic logic [31:0] bus();
        return 32'({busy, avm_chipselect, avm_write_n, avm_address, avm_writedata});
    endfunction

    function automatic logic [31:0] bus_exp(input logic b, input logic cs, input logic wn,
                                            input logic [2:0] a, input logic [15:0] d);
        return 32'({b, cs, wn, a, d});
    endfunction

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    int unsigned base, t0, s0, n, cycles, target;
    logic [31:0] v, p;

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; snap_req = 1'b0;
        period = '0; irq_pulse = 1'b0; irq_hold = 1'b0; tmr_count = '0;
        cyc(2);
        check("rst_bus", bus(), bus_exp(1'b0, 1'b0, 1'b1, 3'd0, 16'h0));
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_tick_count", 32'(tick_count), 32'd0);
        check("rst_snap_value", snap_value, 32'd0);
        check("rst_snap_valid", 32'(snap_valid), 32'd0);
        reset_n = 1'b1;
        cyc(2);

        // Programming sequence, cycle by cycle; period changes after sampling.
        period = 32'h0001_86A0; start = 1'b1;
        cyc(1);
        start = 1'b0; period = $urandom;
        check("wr_pl", bus(), bus_exp(1'b1, 1'b1, 1'b0, 3'd2, 16'h86A0));
        cyc(1);
        check("wr_ph", bus(), bus_exp(1'b1, 1'b1, 1'b0, 3'd3, 16'h0001));
        cyc(1);
        check("wr_ctrl", bus(), bus_exp(1'b1, 1'b1, 1'b0, 3'd1, 16'h0007));
        cyc(1);
        check("run_idle_bus", bus(), bus_exp(1'b1, 1'b0, 1'b1, 3'd0, 16'h0));

        // Three timeouts with random spacing.
        for (int i = 0; i < 3; i++) begin
            cyc($urandom_range(0, 3));
            base = log_q.size(); t0 = tick_seen;
            irq_pulse = 1'b1; cyc(1); irq_pulse = 1'b0; cyc(4);
            exp_ticks = exp_ticks + 16'd1;
            check("irq_tick_pulse", tick_seen - t0, 32'd1);
            check("irq_access_count", log_q.size() - base, 32'd1);
            chk_acc("irq_clr_status", base, 3'd0, 1'b0, 16'h0);
            check("irq_tick_count", 32'(tick_count), 32'(exp_ticks));
        end

        // Snapshots: the directed value followed by random ones.
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 32'h0001_2345 : $urandom;
            tmr_count = v;
            base = log_q.size(); s0 = snap_seen;
            snap_req = 1'b1; cyc(1); snap_req = 1'b0; cyc(7);
            chk_acc("snap_wr4", base, 3'd4, 1'b0, 16'h0);
            chk_acc("snap_rd4", base + 1, 3'd4, 1'b1, 16'h0);
            chk_acc("snap_rd5", base + 2, 3'd5, 1'b1, 16'h0);
            check("snap_access_count", log_q.size() - base, 32'd3);
            check("snap_valid_pulses", snap_seen - s0, 32'd1);
            check("snap_value_at_valid", snap_seen_val, v);
            check("snap_value_held", snap_value, v);
        end

        // Timeout raised mid-snapshot is serviced right after it.
        v = $urandom; tmr_count = v;
        base = log_q.size(); s0 = snap_seen; t0 = tick_seen;
        snap_req = 1'b1; cyc(1); snap_req = 1'b0;
        irq_pulse = 1'b1; cyc(1); irq_pulse = 1'b0; cyc(10);
        exp_ticks = exp_ticks + 16'd1;
        chk_acc("snapirq_wr4", base, 3'd4, 1'b0, 16'h0);
        chk_acc("snapirq_rd4", base + 1, 3'd4, 1'b1, 16'h0);
        chk_acc("snapirq_rd5", base + 2, 3'd5, 1'b1, 16'h0);
        chk_acc("snapirq_clr", base + 3, 3'd0, 1'b0, 16'h0);
        check("snapirq_access_count", log_q.size() - base, 32'd4);
        check("snapirq_value", snap_seen_val, v);
        check("snapirq_ticks", tick_seen - t0, 32'd1);
        check("snapirq_tick_count", 32'(tick_count), 32'(exp_ticks));

        // Drive the count to 0xFFFF with a held interrupt, then wrap with one more.
        target = 32'(16'hFFFF - exp_ticks);
        n = 0; cycles = 0;
        irq_hold = (target != 0);
        while (n < target && cycles < 200000) begin
            @(negedge clk);
            cycles++;
            if (tick) n++;
            if (n == target) irq_hold = 1'b0;
        end
        irq_hold = 1'b0;
        check("preload_ticks", n, target);
        cyc(3);
        exp_ticks = 16'hFFFF;
        check("preload_tick_count", 32'(tick_count), 32'(exp_ticks));
        irq_pulse = 1'b1; cyc(1); irq_pulse = 1'b0; cyc(4);
        exp_ticks = exp_ticks + 16'd1;
        check("wrap_tick_count", 32'(tick_count), 32'(exp_ticks));

        // stop, irq and snap_req together: stop wins, nothing else happens.
        base = log_q.size(); s0 = snap_seen; t0 = tick_seen;
        irq_pulse = 1'b1; cyc(1); irq_pulse = 1'b0;
        stop = 1'b1; snap_req = 1'b1; cyc(1); stop = 1'b0; snap_req = 1'b0; cyc(5);
        chk_acc("stop_wr_ctrl", base, 3'd1, 1'b0, 16'h0008);
        chk_acc("stop_clr", base + 1, 3'd0, 1'b0, 16'h0);
        check("stop_access_count", log_q.size() - base, 32'd2);
        check("stop_no_tick", tick_seen - t0, 32'd0);
        check("stop_no_snap", snap_seen - s0, 32'd0);
        check("stop_idle_bus", bus(), bus_exp(1'b0, 1'b0, 1'b1, 3'd0, 16'h0));

        // stop/snap_req ignored in IDLE.
        base = log_q.size();
        stop = 1'b1; snap_req = 1'b1; cyc(1); stop = 1'b0; snap_req = 1'b0; cyc(3);
        check("idle_ignore_access", log_q.size() - base, 32'd0);
        check("idle_ignore_busy", 32'(busy), 32'd0);

        // Random period restart; a second start while running is ignored.
        p = $urandom;
        base = log_q.size();
        period = p; start = 1'b1; cyc(1); start = 1'b0; cyc(4);
        chk_acc("rnd_wr_pl", base, 3'd2, 1'b0, p[15:0]);
        chk_acc("rnd_wr_ph", base + 1, 3'd3, 1'b0, p[31:16]);
        chk_acc("rnd_wr_ctrl", base + 2, 3'd1, 1'b0, 16'h0007);
        base = log_q.size();
        period = ~p; start = 1'b1; cyc(1); start = 1'b0; cyc(3);
        check("run_start_ignored", log_q.size() - base, 32'd0);
        stop = 1'b1; cyc(1); stop = 1'b0; cyc(4);
        chk_acc("rnd_stop_ctrl", base, 3'd1, 1'b0, 16'h0008);
        chk_acc("rnd_stop_clr", base + 1, 3'd0, 1'b0, 16'h0);

        // stop arriving during programming is held until RUN.
        p = $urandom;
        base = log_q.size();
        period = p; start = 1'b1; cyc(1); start = 1'b0;
        stop = 1'b1; cyc(1); stop = 1'b0; cyc(8);
        chk_acc("pend_wr_pl", base, 3'd2, 1'b0, p[15:0]);
        chk_acc("pend_wr_ph", base + 1, 3'd3, 1'b0, p[31:16]);
        chk_acc("pend_wr_ctrl", base + 2, 3'd1, 1'b0, 16'h0007);
        chk_acc("pend_stop_ctrl", base + 3, 3'd1, 1'b0, 16'h0008);
        chk_acc("pend_stop_clr", base + 4, 3'd0, 1'b0, 16'h0);
        check("pend_busy", 32'(busy), 32'd0);

        // Reset asserted during WR_PH.
        period = $urandom; start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        check("pre_reset_wr_ph", 32'({avm_chipselect, avm_address}), 32'({1'b1, 3'd3}));
        reset_n = 1'b0;
        #1;
        check("midrst_bus", bus(), bus_exp(1'b0, 1'b0, 1'b1, 3'd0, 16'h0));
        check("midrst_tick_count", 32'(tick_count), 32'd0);
        check("midrst_snap_value", snap_value, 32'd0);
        check("midrst_pulses", 32'({tick, snap_valid}), 32'd0);
        base = log_q.size();
        cyc(2);
        reset_n = 1'b1;
        cyc(10);
        check("postrst_no_access", log_q.size() - base, 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
